// File: rtl/thcomp_scan_if.sv
// Request/result bundle for the multi-channel threshold scanner; master drives the
// snapshot inputs and start, slave returns busy/finish and the scan results.
interface thcomp_scan_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int IDXW  = 2
);
  logic                 start;
  logic [NCH*WIDTH-1:0] metric_in;
  logic [WIDTH-1:0]     threshold;
  logic                 ge_mode;
  logic                 busy;
  logic                 finish;
  logic [NCH-1:0]       hit_mask;
  logic                 any_hit;
  logic [WIDTH-1:0]     peak_val;
  logic [IDXW-1:0]      peak_idx;

  modport master (
    output start, metric_in, threshold, ge_mode,
    input  busy, finish, hit_mask, any_hit, peak_val, peak_idx
  );

  modport slave (
    input  start, metric_in, threshold, ge_mode,
    output busy, finish, hit_mask, any_hit, peak_val, peak_idx
  );
endinterface

// File: rtl/thcomp_scan.sv
// Snapshot NCH metrics + threshold on start, compare one channel per clock, publish hit mask with a
// one-cycle finish after NCH cycles. Define THCOMP_SCAN_PEAK_EN to also report the peak metric and its channel.
module thcomp_scan #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int IDXW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  thcomp_scan_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               busy_c, finish_c;

  logic [WIDTH-1:0]   snap [NCH];
  logic [WIDTH-1:0]   snap_thr;
  logic               snap_ge;
  logic [IDXW-1:0]    idx;
  logic [NCH-1:0]     work, work_nxt;
  logic [NCH-1:0]     hit_q;
  logic               any_q;

  logic               last;
  logic [WIDTH-1:0]   cur;
  logic               cur_hit;

  assign last     = (idx == IDXW'(NCH - 1));
  assign cur      = snap[idx];
  assign cur_hit  = snap_ge ? (cur >= snap_thr) : (cur > snap_thr);
  assign work_nxt = work | (NCH'(cur_hit) << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy_c   = 1'b1;
        finish_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Inputs are captured only on accept so the scan is immune to later input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) snap[k] <= '0;
      snap_thr <= '0;
      snap_ge  <= 1'b0;
      idx      <= '0;
      work     <= '0;
      hit_q    <= '0;
      any_q    <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < NCH; k++) snap[k] <= bus.metric_in[k*WIDTH +: WIDTH];
      snap_thr <= bus.threshold;
      snap_ge  <= bus.ge_mode;
      idx      <= '0;
      work     <= '0;
    end else if (state == SCAN) begin
      work <= work_nxt;
      if (last) begin
        hit_q <= work_nxt;
        any_q <= |work_nxt;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.finish   = finish_c;
  assign bus.hit_mask = hit_q;
  assign bus.any_hit  = any_q;

`ifdef THCOMP_SCAN_PEAK_EN
  logic [WIDTH-1:0] pk_val, pk_val_nxt, pv_q;
  logic [IDXW-1:0]  pk_idx, pk_idx_nxt, pi_q;

  // Channel 0 seeds the tracker; strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    pk_val_nxt = pk_val;
    pk_idx_nxt = pk_idx;
    if (idx == '0 || cur > pk_val) begin
      pk_val_nxt = cur;
      pk_idx_nxt = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_val <= '0;
      pk_idx <= '0;
      pv_q   <= '0;
      pi_q   <= '0;
    end else if (accept) begin
      pk_val <= '0;
      pk_idx <= '0;
    end else if (state == SCAN) begin
      pk_val <= pk_val_nxt;
      pk_idx <= pk_idx_nxt;
      if (last) begin
        pv_q <= pk_val_nxt;
        pi_q <= pk_idx_nxt;
      end
    end
  end

  assign bus.peak_val = pv_q;
  assign bus.peak_idx = pi_q;
`else
  assign bus.peak_val = '0;
  assign bus.peak_idx = '0;
`endif

endmodule

// File: tb/tb_thcomp_scan.sv
// Directed bench for thcomp_scan: compare modes, boundaries, back-to-back starts, mid-scan reset, peak outputs.
module tb_thcomp_scan;
  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int IDXW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  thcomp_scan_if #(.WIDTH(WIDTH), .NCH(NCH), .IDXW(IDXW)) bus ();

  thcomp_scan #(.WIDTH(WIDTH), .NCH(NCH), .IDXW(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*WIDTH-1:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Peak outputs read zero when the tracker is compiled out.
  function automatic logic [31:0] pk(input logic [31:0] v);
`ifdef THCOMP_SCAN_PEAK_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic [15:0] thr, input logic ge, input logic [NCH*WIDTH-1:0] met);
    bus.threshold = thr;
    bus.ge_mode   = ge;
    bus.metric_in = met;
  endtask

  // Called at a negedge; one start pulse, then observe 8 negedges.
  task automatic run_scan(input logic [15:0] thr, input logic ge, input logic [NCH*WIDTH-1:0] met,
                          output int fk, output int bcnt, output int fcnt,
                          output logic [3:0] pre, output logic [3:0] msk, output logic any,
                          output logic [15:0] pv, output logic [1:0] pi);
    drive(thr, ge, met);
    bus.start = 1'b1;
    fk = 0; bcnt = 0; fcnt = 0; pre = '0; msk = '0; any = 1'b0; pv = '0; pi = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (k == 4) pre = bus.hit_mask;
      if (bus.finish) begin
        fcnt++;
        if (fk == 0) begin
          fk  = k;
          msk = bus.hit_mask;
          any = bus.any_hit;
          pv  = bus.peak_val;
          pi  = bus.peak_idx;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fk, bcnt, fcnt;
    logic [3:0] pre, msk;
    logic any;
    logic [15:0] pv;
    logic [1:0] pi;

    rst_n = 1'b0;
    bus.start = 1'b0;
    drive(16'd0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_finish", 32'(bus.finish), 32'd0);
    check("rst_mask", 32'(bus.hit_mask), 32'd0);
    check("rst_any", 32'(bus.any_hit), 32'd0);
    check("rst_pv", 32'(bus.peak_val), 32'd0);
    check("rst_pi", 32'(bus.peak_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: strict compare
    run_scan(16'd100, 1'b0, pack4(16'd50, 16'd100, 16'd101, 16'd200), fk, bcnt, fcnt, pre, msk, any, pv, pi);
    check("t1_latency", 32'(fk), 32'd5);
    check("t1_busy_cycles", 32'(bcnt), 32'd5);
    check("t1_finish_count", 32'(fcnt), 32'd1);
    check("t1_pre_mask", 32'(pre), 32'd0);
    check("t1_mask", 32'(msk), 32'b1100);
    check("t1_any", 32'(any), 32'd1);
    check("t1_pv", 32'(pv), pk(32'd200));
    check("t1_pi", 32'(pi), pk(32'd3));
    check("t1_mask_hold", 32'(bus.hit_mask), 32'b1100);

    // 2: >= compare, previous mask holds during scan
    run_scan(16'd100, 1'b1, pack4(16'd50, 16'd100, 16'd101, 16'd200), fk, bcnt, fcnt, pre, msk, any, pv, pi);
    check("t2_latency", 32'(fk), 32'd5);
    check("t2_pre_mask", 32'(pre), 32'b1100);
    check("t2_mask", 32'(msk), 32'b1110);

    // 3: all zero
    run_scan(16'd0, 1'b0, '0, fk, bcnt, fcnt, pre, msk, any, pv, pi);
    check("t3a_mask", 32'(msk), 32'd0);
    check("t3a_any", 32'(any), 32'd0);
    check("t3a_pv", 32'(pv), 32'd0);
    run_scan(16'd0, 1'b1, '0, fk, bcnt, fcnt, pre, msk, any, pv, pi);
    check("t3b_mask", 32'(msk), 32'b1111);
    check("t3b_any", 32'(any), 32'd1);

    // 4: start held high, inputs churn every cycle; accepts land at k=0,5,10
    drive(16'd100, 1'b0, pack4(16'd50, 16'd100, 16'd101, 16'd200));
    bus.start = 1'b1;
    fcnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.finish) fcnt++;
      if (k == 5) begin
        check("t4a_finish", 32'(bus.finish), 32'd1);
        check("t4a_mask", 32'(bus.hit_mask), 32'b1100);
        check("t4a_pv", 32'(bus.peak_val), pk(32'd200));
      end
      if (k == 10) begin
        check("t4b_finish", 32'(bus.finish), 32'd1);
        check("t4b_mask", 32'(bus.hit_mask), 32'b0101);
        check("t4b_pv", 32'(bus.peak_val), pk(32'd11));
        check("t4b_pi", 32'(bus.peak_idx), pk(32'd2));
      end
      if (k == 15) begin
        check("t4c_finish", 32'(bus.finish), 32'd1);
        check("t4c_mask", 32'(bus.hit_mask), 32'b1001);
        check("t4c_any", 32'(bus.any_hit), 32'd1);
        check("t4c_pv", 32'(bus.peak_val), pk(32'hFFFF));
        check("t4c_pi", 32'(bus.peak_idx), pk(32'd0));
      end
      if (k == 5)       drive(16'd10, 1'b1, pack4(16'd10, 16'd9, 16'd11, 16'd0));
      else if (k == 10) drive(16'hFFFF, 1'b1, pack4(16'hFFFF, 16'd0, 16'hFFFE, 16'hFFFF));
      else              drive(16'(k), 1'b1, pack4(16'h8000, 16'h8001, 16'h8002, 16'h8003 + 16'(k)));
      if (k == 15) bus.start = 1'b0;
    end
    check("t4_finish_count", 32'(fcnt), 32'd3);
    @(negedge clk);
    check("t4_idle_busy", 32'(bus.busy), 32'd0);
    check("t4_idle_mask", 32'(bus.hit_mask), 32'b1001);

    // 5: reset during second scan cycle
    drive(16'd100, 1'b0, pack4(16'd50, 16'd100, 16'd101, 16'd200));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_finish", 32'(bus.finish), 32'd0);
    check("t5_rst_mask", 32'(bus.hit_mask), 32'd0);
    check("t5_rst_any", 32'(bus.any_hit), 32'd0);
    check("t5_rst_pv", 32'(bus.peak_val), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.finish || bus.busy) fcnt++;
    end
    check("t5_no_activity", 32'(fcnt), 32'd0);
    run_scan(16'd100, 1'b0, pack4(16'd50, 16'd100, 16'd101, 16'd200), fk, bcnt, fcnt, pre, msk, any, pv, pi);
    check("t5_latency", 32'(fk), 32'd5);
    check("t5_mask", 32'(msk), 32'b1100);

    // 6: peak tie keeps lowest index
    run_scan(16'd100, 1'b0, pack4(16'd7, 16'd300, 16'd300, 16'd12), fk, bcnt, fcnt, pre, msk, any, pv, pi);
    check("t6_mask", 32'(msk), 32'b0110);
    check("t6_pv", 32'(pv), pk(32'd300));
    check("t6_pi", 32'(pi), pk(32'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
